// File: rtl/game_pkg.sv
// Shared types and constants for the dino game run-state logic.
package game_pkg;

  localparam int SPEED_W = 3;

  typedef enum logic [1:0] {
    ATTRACT  = 2'd0,
    RUNNING  = 2'd1,
    DYING    = 2'd2,
    GAMEOVER = 2'd3
  } game_state_t;

  // Counter width for a count range of n values, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-FF synchroniser, stability debounce and a
// one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
    end
  end

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive clocks; any bounce back restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync1;
        r_cnt   <= '0;
        r_press <= r_sync1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/game_sequencer.sv
// Run-state controller for the dino game: attract/run/death/game-over
// sequencing, score tick and scroll-speed scheduling off the frame strobe.
module game_sequencer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int SCORE_FRAMES      = 6,
  parameter int SPEED_STEP_FRAMES = 600,
  parameter int MAX_SPEED         = 7,
  parameter int DEATH_FRAMES      = 30,
  parameter int LOCK_FRAMES       = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn1,
  input  logic               frame_strobe,
  input  logic               collision,
  output logic               gameon,
  output logic [1:0]         game_state,
  output logic               score_tick,
  output logic               jump_req,
  output logic               world_reset,
  output logic [SPEED_W-1:0] scroll_speed,
  output logic               flash
);

  localparam int SC_W = cnt_w(SCORE_FRAMES);
  localparam int SP_W = cnt_w(SPEED_STEP_FRAMES);
  localparam int DT_W = cnt_w(DEATH_FRAMES);
  localparam int LK_W = cnt_w(LOCK_FRAMES + 1);

  localparam logic [SC_W-1:0]    SC_LAST = SC_W'(SCORE_FRAMES - 1);
  localparam logic [SP_W-1:0]    SP_LAST = SP_W'(SPEED_STEP_FRAMES - 1);
  localparam logic [DT_W-1:0]    DT_LAST = DT_W'(DEATH_FRAMES - 1);
  localparam logic [LK_W-1:0]    LK_LAST = LK_W'(LOCK_FRAMES);
  localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(MAX_SPEED);

  game_state_t        r_state;
  logic               r_gameon;
  logic               r_score_tick;
  logic               r_jump_req;
  logic               r_world_reset;
  logic [SPEED_W-1:0] r_speed;
  logic               r_flash;
  logic [1:0]         r_flash_div;
  logic [SC_W-1:0]    r_score_cnt;
  logic [SP_W-1:0]    r_speed_cnt;
  logic [DT_W-1:0]    r_death_cnt;
  logic [LK_W-1:0]    r_lock_cnt;

  logic w_press;
  logic w_start;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn1),
    .o_press(w_press)
  );

  // A press starts a run from attract, or from game-over once the lock has expired.
  assign w_start = w_press &&
                   ((r_state == ATTRACT) ||
                    ((r_state == GAMEOVER) && (r_lock_cnt == LK_LAST)));

  // Run-state FSM with its frame counters; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ATTRACT;
      r_gameon      <= 1'b0;
      r_score_tick  <= 1'b0;
      r_jump_req    <= 1'b0;
      r_world_reset <= 1'b0;
      r_speed       <= '0;
      r_flash       <= 1'b0;
      r_flash_div   <= '0;
      r_score_cnt   <= '0;
      r_speed_cnt   <= '0;
      r_death_cnt   <= '0;
      r_lock_cnt    <= '0;
    end else begin
      r_score_tick  <= 1'b0;
      r_jump_req    <= 1'b0;
      r_world_reset <= 1'b0;
      if (w_start) begin
        r_state       <= RUNNING;
        r_gameon      <= 1'b1;
        r_world_reset <= 1'b1;
        r_speed       <= SPEED_W'(1);
        r_score_cnt   <= '0;
        r_speed_cnt   <= '0;
      end else begin
        case (r_state)
          RUNNING: begin
            if (frame_strobe && collision) begin
              // Death takes priority over a press landing in the same cycle.
              r_state     <= DYING;
              r_gameon    <= 1'b0;
              r_speed     <= '0;
              r_death_cnt <= '0;
              r_flash_div <= '0;
              r_flash     <= 1'b0;
            end else begin
              r_jump_req <= w_press;
              if (frame_strobe) begin
                if (r_score_cnt == SC_LAST) begin
                  r_score_cnt  <= '0;
                  r_score_tick <= 1'b1;
                end else begin
                  r_score_cnt <= r_score_cnt + 1'b1;
                end
                if (r_speed_cnt == SP_LAST) begin
                  r_speed_cnt <= '0;
                  if (r_speed < SPD_MAX) r_speed <= r_speed + 1'b1;
                end else begin
                  r_speed_cnt <= r_speed_cnt + 1'b1;
                end
              end
            end
          end
          DYING: begin
            if (frame_strobe) begin
              if (r_death_cnt == DT_LAST) begin
                r_state    <= GAMEOVER;
                r_flash    <= 1'b0;
                r_lock_cnt <= '0;
              end else begin
                r_death_cnt <= r_death_cnt + 1'b1;
                r_flash_div <= r_flash_div + 1'b1;
                if (r_flash_div == 2'd3) r_flash <= ~r_flash;
              end
            end
          end
          GAMEOVER: begin
            if (frame_strobe && (r_lock_cnt != LK_LAST)) r_lock_cnt <= r_lock_cnt + 1'b1;
          end
          default: begin
            r_state <= ATTRACT;
          end
        endcase
      end
    end
  end

  assign game_state   = r_state;
  assign gameon       = r_gameon;
  assign score_tick   = r_score_tick;
  assign jump_req     = r_jump_req;
  assign world_reset  = r_world_reset;
  assign scroll_speed = r_speed;
  assign flash        = r_flash;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with shortened timing parameters.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn1 = 1'b0;
  logic       frame_strobe = 1'b0;
  logic       collision = 1'b0;
  logic       gameon;
  logic [1:0] game_state;
  logic       score_tick;
  logic       jump_req;
  logic       world_reset;
  logic [2:0] scroll_speed;
  logic       flash;

  int vectors = 0;
  int errors  = 0;

  game_sequencer #(
    .DEBOUNCE_CYCLES  (4),
    .SCORE_FRAMES     (3),
    .SPEED_STEP_FRAMES(5),
    .MAX_SPEED        (2),
    .DEATH_FRAMES     (2),
    .LOCK_FRAMES      (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn1        (btn1),
    .frame_strobe(frame_strobe),
    .collision   (collision),
    .gameon      (gameon),
    .game_state  (game_state),
    .score_tick  (score_tick),
    .jump_req    (jump_req),
    .world_reset (world_reset),
    .scroll_speed(scroll_speed),
    .flash       (flash)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic col);
    frame_strobe = 1'b1;
    collision    = col;
    tick();
    frame_strobe = 1'b0;
    collision    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vectors++; if (game_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", game_state); end
    vectors++; if ({gameon, score_tick, jump_req, world_reset, flash} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {gameon, score_tick, jump_req, world_reset, flash}); end
    vectors++; if (scroll_speed !== 3'd0) begin errors++; $display("FAIL reset_speed: got %0d want 0", scroll_speed); end
    rst_n = 1'b1;
    tick();
    strobe(1'b0);
    vectors++; if (game_state !== 2'd0 || score_tick !== 1'b0 || scroll_speed !== 3'd0) begin errors++; $display("FAIL attract_strobe: got state %0d tick %b speed %0d want 0 0 0", game_state, score_tick, scroll_speed); end
  endtask

  task automatic test_start();
    int wr = 0;
    int moved = 0;
    btn1 = 1'b1;
    repeat (2) tick();
    btn1 = 1'b0;
    repeat (12) begin
      tick();
      if (world_reset === 1'b1) wr++;
      if (game_state !== 2'd0) moved++;
    end
    vectors++; if (wr != 0 || moved != 0) begin errors++; $display("FAIL glitch: got %0d wr %0d moves want 0 0", wr, moved); end
    btn1 = 1'b1;
    repeat (6) tick();
    vectors++; if (game_state !== 2'd0) begin errors++; $display("FAIL start_early: got %0d want 0", game_state); end
    btn1 = 1'b0;
    tick();
    vectors++; if (game_state !== 2'd1 || world_reset !== 1'b1) begin errors++; $display("FAIL start: got state %0d wr %b want 1 1", game_state, world_reset); end
    vectors++; if (scroll_speed !== 3'd1 || gameon !== 1'b1) begin errors++; $display("FAIL start_speed: got speed %0d gameon %b want 1 1", scroll_speed, gameon); end
    tick();
    vectors++; if (world_reset !== 1'b0) begin errors++; $display("FAIL wr_pulse: got %b want 0", world_reset); end
    repeat (8) tick();
  endtask

  task automatic test_scoring();
    for (int i = 1; i <= 10; i++) begin
      strobe(1'b0);
      vectors++; if (score_tick !== ((i % 3) == 0)) begin errors++; $display("FAIL score_tick_%0d: got %b want %b", i, score_tick, ((i % 3) == 0)); end
      vectors++; if (scroll_speed !== ((i >= 5) ? 3'd2 : 3'd1)) begin errors++; $display("FAIL speed_%0d: got %0d want %0d", i, scroll_speed, (i >= 5) ? 2 : 1); end
    end
    tick();
    vectors++; if (score_tick !== 1'b0) begin errors++; $display("FAIL tick_width: got %b want 0", score_tick); end
  endtask

  task automatic test_collision();
    int jr = 0;
    strobe(1'b0);
    vectors++; if (score_tick !== 1'b0) begin errors++; $display("FAIL pre_col_tick: got %b want 0", score_tick); end
    btn1 = 1'b1;
    repeat (6) tick();
    frame_strobe = 1'b1;
    collision    = 1'b1;
    tick();
    frame_strobe = 1'b0;
    collision    = 1'b0;
    vectors++; if (game_state !== 2'd2) begin errors++; $display("FAIL col_state: got %0d want 2", game_state); end
    vectors++; if (jump_req !== 1'b0 || score_tick !== 1'b0) begin errors++; $display("FAIL col_pulses: got jump %b tick %b want 0 0", jump_req, score_tick); end
    vectors++; if (scroll_speed !== 3'd0 || gameon !== 1'b0) begin errors++; $display("FAIL col_outputs: got speed %0d gameon %b want 0 0", scroll_speed, gameon); end
    btn1 = 1'b0;
    repeat (10) begin
      tick();
      if (jump_req === 1'b1) jr++;
    end
    vectors++; if (jr != 0) begin errors++; $display("FAIL dying_jump: got %0d want 0", jr); end
    strobe(1'b0);
    vectors++; if (game_state !== 2'd2 || flash !== 1'b0) begin errors++; $display("FAIL dying_1: got state %0d flash %b want 2 0", game_state, flash); end
    strobe(1'b0);
    vectors++; if (game_state !== 2'd3) begin errors++; $display("FAIL dying_2: got %0d want 3", game_state); end
  endtask

  task automatic test_gameover();
    int moved = 0;
    strobe(1'b0);
    btn1 = 1'b1;
    repeat (6) tick();
    btn1 = 1'b0;
    repeat (10) begin
      tick();
      if (game_state !== 2'd3) moved++;
    end
    vectors++; if (moved != 0) begin errors++; $display("FAIL locked_press: got %0d exits want 0", moved); end
    strobe(1'b0);
    strobe(1'b0);
    tick();
    vectors++; if (game_state !== 2'd3) begin errors++; $display("FAIL not_queued: got %0d want 3", game_state); end
    btn1 = 1'b1;
    repeat (6) tick();
    btn1 = 1'b0;
    tick();
    vectors++; if (game_state !== 2'd1 || world_reset !== 1'b1) begin errors++; $display("FAIL restart: got state %0d wr %b want 1 1", game_state, world_reset); end
    vectors++; if (scroll_speed !== 3'd1) begin errors++; $display("FAIL restart_speed: got %0d want 1", scroll_speed); end
    repeat (9) tick();
    for (int i = 1; i <= 3; i++) begin
      strobe(1'b0);
      vectors++; if (score_tick !== (i == 3)) begin errors++; $display("FAIL restart_tick_%0d: got %b want %b", i, score_tick, (i == 3)); end
    end
  endtask

  task automatic test_jump();
    for (int p = 0; p < 2; p++) begin
      int jr = 0;
      btn1 = 1'b1;
      repeat (20) begin
        tick();
        if (jump_req === 1'b1) jr++;
      end
      btn1 = 1'b0;
      repeat (10) begin
        tick();
        if (jump_req === 1'b1) jr++;
      end
      vectors++; if (jr != 1) begin errors++; $display("FAIL jump_count_%0d: got %0d want 1", p, jr); end
    end
    vectors++; if (game_state !== 2'd1) begin errors++; $display("FAIL jump_state: got %0d want 1", game_state); end
  endtask

  task automatic test_reset_mid_run();
    int wr = 0;
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b0);
    vectors++; if (score_tick !== 1'b1 || scroll_speed !== 3'd2) begin errors++; $display("FAIL pre_reset: got tick %b speed %0d want 1 2", score_tick, scroll_speed); end
    rst_n = 1'b0;
    #2;
    vectors++; if (game_state !== 2'd0 || scroll_speed !== 3'd0) begin errors++; $display("FAIL async_reset: got state %0d speed %0d want 0 0", game_state, scroll_speed); end
    vectors++; if ({gameon, score_tick, jump_req, world_reset, flash} !== 5'b0) begin errors++; $display("FAIL async_flags: got %b want 00000", {gameon, score_tick, jump_req, world_reset, flash}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      if (world_reset === 1'b1 || game_state !== 2'd0) wr++;
    end
    vectors++; if (wr != 0) begin errors++; $display("FAIL post_reset: got %0d bad cycles want 0", wr); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_scoring();
    test_collision();
    test_gameover();
    test_jump();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
